mem_access_stage: RTL and testbench

- MEM pipeline stage: consumes the EX/MEM pipeline register outputs and drives the data-memory request/acknowledge interface.
- Stalls upstream stages while a memory access is outstanding.
- Registers results into the MEM/WB pipeline register outputs.
- Handles variable-latency memory, word-misalignment detection and a bounded-wait timeout.

---
 rtl/mem_access_stage_if.sv | 26 ++
 rtl/mem_access_stage.sv | 140 ++++++++++++++
 tb/tb_mem_access_stage.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage_if
//  Purpose  : Data-memory request/acknowledge bus between the MEM stage
//             (master) and the data memory (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_access_stage_if;
  logic        mem_req_o;    // request, held high until ack or abort
  logic        mem_we_o;     // 1 = write, valid with req
  logic [31:0] mem_addr_o;   // word-aligned address, valid with req
  logic [31:0] mem_wdata_o;  // store data, valid with req
  logic        mem_ack_i;    // single-cycle completion strobe
  logic [31:0] mem_rdata_i;  // read data, valid with ack on reads

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage
//  Purpose  : MEM pipeline stage. Issues data-memory accesses, stalls the
//             upstream pipe while an access is outstanding, flags misaligned
//             accesses and aborts accesses that wait too long for an ack.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
  parameter int TIMEOUT = 16,  // max WAIT cycles without ack (1..255)
  parameter int CNT_W   = 8    // wait counter width, must hold TIMEOUT
) (
  input  wire logic        clk_i,
  input  wire logic        rst_i,      // asynchronous, active-low
  input  wire logic [1:0]  WB_i,       // [1]=RegWrite, [0]=MemtoReg
  input  wire logic [1:0]  M_i,        // [1]=MemRead,  [0]=MemWrite
  input  wire logic [31:0] DMaddr_i,
  input  wire logic [31:0] DMdata_i,
  input  wire logic [4:0]  RDaddr_i,
  mem_access_stage_if.master mem,
  output logic             stall_o,
  output logic [1:0]       WB_o,
  output logic [31:0]      MEMdata_o,
  output logic [31:0]      ALUres_o,
  output logic [4:0]       RDaddr_o,
  output logic             err_o
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST_WAIT = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;

  logic w_op;
  logic w_mis;
  logic w_timeout;

  // Decode the EX/MEM control: M_i=11 counts as a write (MemWrite wins).
  assign w_op      = M_i[1] | M_i[0];
  assign w_mis     = w_op & (DMaddr_i[1:0] != 2'b00);
  assign w_timeout = (r_cnt == C_LAST_WAIT);

  // Stall while an aligned access is being launched or is still pending;
  // released on the cycle the access completes or is aborted.
  always_comb begin
    stall_o = 1'b0;
    if (rst_i) begin
      if (r_state == S_IDLE) begin
        stall_o = w_op & ~w_mis;
      end else begin
        stall_o = ~(mem.mem_ack_i | w_timeout);
      end
    end
  end

  // Access FSM plus MEM/WB pipeline register; all outputs registered.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      WB_o      <= 2'b00;
      MEMdata_o <= '0;
      ALUres_o  <= '0;
      RDaddr_o  <= '0;
      err_o     <= 1'b0;
    end else begin
      err_o <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_mis) begin
            // Misaligned: no request, squash writeback, report error.
            err_o    <= 1'b1;
            WB_o     <= 2'b00;
            ALUres_o <= DMaddr_i;
            RDaddr_o <= RDaddr_i;
          end else if (w_op) begin
            // Launch the access; MEM/WB sees a bubble meanwhile.
            r_state <= S_WAIT;
            r_cnt   <= '0;
            r_req   <= 1'b1;
            r_we    <= M_i[0];
            r_addr  <= {DMaddr_i[31:2], 2'b00};
            r_wdata <= DMdata_i;
            WB_o    <= 2'b00;
          end else begin
            // Plain ALU result passes straight through.
            WB_o     <= WB_i;
            ALUres_o <= DMaddr_i;
            RDaddr_o <= RDaddr_i;
          end
        end
        S_WAIT: begin
          if (mem.mem_ack_i) begin
            r_state  <= S_IDLE;
            r_req    <= 1'b0;
            WB_o     <= WB_i;
            ALUres_o <= DMaddr_i;
            RDaddr_o <= RDaddr_i;
            if (!M_i[0]) begin
              MEMdata_o <= mem.mem_rdata_i;
            end
          end else if (w_timeout) begin
            // Give up on the access and squash the instruction.
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            err_o   <= 1'b1;
            WB_o    <= 2'b00;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            WB_o  <= 2'b00;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req_o   = r_req;
  assign mem.mem_we_o    = r_we;
  assign mem.mem_addr_o  = r_addr;
  assign mem.mem_wdata_o = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_stage
//  Purpose  : Self-checking bench for mem_access_stage (TIMEOUT = 4).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [1:0]  WB_i = '0;
  logic [1:0]  M_i = '0;
  logic [31:0] DMaddr_i = '0;
  logic [31:0] DMdata_i = '0;
  logic [4:0]  RDaddr_i = '0;
  logic        stall_o;
  logic [1:0]  WB_o;
  logic [31:0] MEMdata_o;
  logic [31:0] ALUres_o;
  logic [4:0]  RDaddr_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  mem_access_stage_if mif();

  mem_access_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .WB_i      (WB_i),
    .M_i       (M_i),
    .DMaddr_i  (DMaddr_i),
    .DMdata_i  (DMdata_i),
    .RDaddr_i  (RDaddr_i),
    .mem       (mif.master),
    .stall_o   (stall_o),
    .WB_o      (WB_o),
    .MEMdata_o (MEMdata_o),
    .ALUres_o  (ALUres_o),
    .RDaddr_o  (RDaddr_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    mif.mem_ack_i   = 1'b0;
    mif.mem_rdata_i = '0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An access is "in flight" from launch until ack or until TO cycles of
  // waiting have elapsed; the model tracks only that and the MEM/WB values.
  bit          m_busy = 0;
  int          m_waited = 0;
  logic        e_req = 0, e_we = 0, e_err = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_mem = 0, e_alu = 0;
  logic [1:0]  e_wb = 0;
  logic [4:0]  e_rd = 0;

  always @(posedge clk or negedge rst_i) begin
    bit is_op, is_mis;
    if (!rst_i) begin
      m_busy = 0; m_waited = 0;
      e_req = 0; e_we = 0; e_err = 0; e_addr = 0; e_wdata = 0;
      e_mem = 0; e_alu = 0; e_wb = 0; e_rd = 0;
    end else begin
      is_op  = (M_i != 2'b00);
      is_mis = is_op && (DMaddr_i % 4 != 0);
      e_err  = 0;
      if (!m_busy) begin
        if (is_mis) begin
          e_err = 1; e_wb = 0; e_alu = DMaddr_i; e_rd = RDaddr_i;
        end else if (is_op) begin
          m_busy = 1; m_waited = 0;
          e_req = 1; e_we = M_i[0];
          e_addr = DMaddr_i - (DMaddr_i % 4); e_wdata = DMdata_i; e_wb = 0;
        end else begin
          e_wb = WB_i; e_alu = DMaddr_i; e_rd = RDaddr_i;
        end
      end else if (mif.mem_ack_i) begin
        m_busy = 0; e_req = 0;
        e_wb = WB_i; e_alu = DMaddr_i; e_rd = RDaddr_i;
        if (M_i == 2'b10) e_mem = mif.mem_rdata_i;
      end else if (m_waited + 1 >= TO) begin
        m_busy = 0; e_req = 0; e_err = 1; e_wb = 0;
      end else begin
        m_waited++; e_wb = 0;
      end
    end
  end

  function automatic logic exp_stall();
    if (!rst_i) return 1'b0;
    if (!m_busy) return (M_i != 2'b00) && (DMaddr_i % 4 == 0);
    return !(mif.mem_ack_i || (m_waited + 1 >= TO));
  endfunction

  // Per-cycle compare, mid-cycle when everything is settled.
  always @(negedge clk) begin
    chk("stall",   {31'b0, stall_o},        {31'b0, exp_stall()});
    chk("req",     {31'b0, mif.mem_req_o},  {31'b0, e_req});
    chk("err",     {31'b0, err_o},          {31'b0, e_err});
    chk("WB_o",    {30'b0, WB_o},           {30'b0, e_wb});
    chk("MEMdata", MEMdata_o,               e_mem);
    chk("ALUres",  ALUres_o,                e_alu);
    chk("RDaddr",  {27'b0, RDaddr_o},       {27'b0, e_rd});
    if (e_req) begin
      chk("we",    {31'b0, mif.mem_we_o},   {31'b0, e_we});
      chk("addr",  mif.mem_addr_o,          e_addr);
      chk("wdata", mif.mem_wdata_o,         e_wdata);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] wb, input logic [1:0] m,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] rd);
    WB_i = wb; M_i = m; DMaddr_i = a; DMdata_i = d; RDaddr_i = rd;
  endtask

  initial begin
    int sc, rq;
    // Reset held with an aggressive load pattern on the inputs.
    set_in(2'b11, 2'b10, 32'h100, 32'hFFFF_FFFF, 5'd31);
    mif.mem_ack_i = 1'b1; mif.mem_rdata_i = 32'h5555_5555;
    repeat (3) tick();
    chk("rst_req",   {31'b0, mif.mem_req_o}, 32'd0);
    chk("rst_stall", {31'b0, stall_o},       32'd0);

    // Release mid-cycle with an ALU op: nothing moves before the edge.
    #2;
    mif.mem_ack_i = 1'b0;
    set_in(2'b10, 2'b00, 32'h1234, 32'h0, 5'd5);
    rst_i = 1'b1;
    #1;
    chk("rel_WB", {30'b0, WB_o}, 32'd0);
    tick();
    chk("alu_WB",  {30'b0, WB_o},     32'd2);
    chk("alu_res", ALUres_o,          32'h1234);
    chk("alu_rd",  {27'b0, RDaddr_o}, 32'd5);

    // Load, ack in the 4th request cycle (last one before timeout).
    set_in(2'b11, 2'b10, 32'h100, 32'h0, 5'd7);
    sc = 0; rq = 0;
    for (int k = 0; k < 5; k++) begin
      mif.mem_ack_i   = (k == 4);
      mif.mem_rdata_i = (k == 4) ? 32'hDEAD_BEEF : 32'h0;
      #1;
      sc += int'(stall_o); rq += int'(mif.mem_req_o);
      tick();
    end
    mif.mem_ack_i = 1'b0;
    chk("ld_stall_cnt", sc, 32'd4);
    chk("ld_req_cnt",   rq, 32'd4);
    chk("ld_WB",   {30'b0, WB_o}, 32'd3);
    chk("ld_data", MEMdata_o,     32'hDEAD_BEEF);

    // Store, then load back-to-back from the same word.
    set_in(2'b00, 2'b01, 32'h8, 32'hA5A5_A5A5, 5'd3);
    tick();
    chk("st_we",    {31'b0, mif.mem_we_o}, 32'd1);
    chk("st_wdata", mif.mem_wdata_o,       32'hA5A5_A5A5);
    mif.mem_ack_i = 1'b1;
    tick();
    mif.mem_ack_i = 1'b0;
    chk("st_WB", {30'b0, WB_o}, 32'd0);
    set_in(2'b11, 2'b10, 32'h8, 32'h0, 5'd9);
    #1;
    chk("gap_req", {31'b0, mif.mem_req_o}, 32'd0);
    tick();
    chk("ld2_req", {31'b0, mif.mem_req_o}, 32'd1);
    mif.mem_ack_i = 1'b1; mif.mem_rdata_i = 32'h1234_5678;
    tick();
    mif.mem_ack_i = 1'b0;
    chk("ld2_data", MEMdata_o,         32'h1234_5678);
    chk("ld2_rd",   {27'b0, RDaddr_o}, 32'd9);

    // Misaligned load.
    set_in(2'b11, 2'b10, 32'h102, 32'h0, 5'd4);
    #1;
    chk("mis_stall", {31'b0, stall_o}, 32'd0);
    tick();
    chk("mis_err", {31'b0, err_o},     32'd1);
    chk("mis_WB",  {30'b0, WB_o},      32'd0);
    chk("mis_alu", ALUres_o,           32'h102);
    set_in(2'b10, 2'b00, 32'h44, 32'h0, 5'd6);
    tick();
    chk("mis_err_off", {31'b0, err_o}, 32'd0);

    // Timeout: load never acknowledged.
    set_in(2'b11, 2'b10, 32'h200, 32'h0, 5'd8);
    sc = 0; rq = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      sc += int'(stall_o); rq += int'(mif.mem_req_o);
      tick();
    end
    chk("to_stall_cnt", sc, 32'd4);
    chk("to_req_cnt",   rq, 32'd4);
    chk("to_err", {31'b0, err_o}, 32'd1);
    chk("to_WB",  {30'b0, WB_o},  32'd0);
    // Late ack while idle is ignored.
    set_in(2'b10, 2'b00, 32'h50, 32'h0, 5'd2);
    mif.mem_ack_i = 1'b1; mif.mem_rdata_i = 32'hBAD0_BAD0;
    tick();
    mif.mem_ack_i = 1'b0;
    chk("late_ack_data", MEMdata_o, 32'h1234_5678);

    // M_i=11 is a write; read data must not be captured.
    set_in(2'b00, 2'b11, 32'h10, 32'h0BAD_F00D, 5'd1);
    tick();
    chk("w11_we", {31'b0, mif.mem_we_o}, 32'd1);
    tick();
    mif.mem_ack_i = 1'b1; mif.mem_rdata_i = 32'hCAFE_0000;
    tick();
    mif.mem_ack_i = 1'b0;
    chk("w11_data", MEMdata_o, 32'h1234_5678);

    // Reset asserted during WAIT drops the request at once.
    set_in(2'b11, 2'b10, 32'h300, 32'h0, 5'd8);
    tick();
    tick();
    chk("rw_req_pre", {31'b0, mif.mem_req_o}, 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("rw_req_async", {31'b0, mif.mem_req_o}, 32'd0);
    tick();
    set_in(2'b10, 2'b00, 32'h60, 32'h0, 5'd3);
    rst_i = 1'b1;
    tick();
    chk("post_rst_WB", {30'b0, WB_o}, 32'd2);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
